// File: rtl/pipe_add_pkg.sv
// rtl/pipe_add_pkg.sv - op-mode constants and chunk geometry helpers for pipe_add
package pipe_add_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic int chunk_lsb(input int idx, input int chunk);
      return idx * chunk;
   endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// rtl/pipe_add_stage.sv - one ripple-carry chunk rank with valid bit and advance logic
// PIPE_ADD_OVF_EN builds the signed-overflow register in the last rank only.
module pipe_add_stage
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   input  logic [WIDTH-1:0] up_sum,
   input  logic             up_carry,
   input  logic             dn_open,
   output logic             advance,
   output logic             valid,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int LO = chunk_lsb(IDX, CHUNK);
   localparam int HI = LO + CHUNK;
   localparam bit LAST = (HI == WIDTH);
   // operand bits at or below this chunk are consumed here and never travel further
   localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << HI;

   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic [CHUNK:0]   part;
   logic [WIDTH-1:0] sum_nxt;

   assign ca   = up_a[LO +: CHUNK];
   assign cb   = up_b[LO +: CHUNK];
   assign part = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, up_carry};

   always_comb begin
      sum_nxt = up_sum;
      sum_nxt[LO +: CHUNK] = part[CHUNK-1:0];
   end

   assign advance = !valid || dn_open;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         a     <= '0;
         b     <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else if (advance) begin
         valid <= up_valid;
         if (up_valid) begin
            a     <= up_a & KEEP;
            b     <= up_b & KEEP;
            sum   <= sum_nxt;
            carry <= part[CHUNK];
         end
      end
   end

`ifdef PIPE_ADD_OVF_EN
   if (LAST) begin : g_ovf
      logic msb_cin;
      // carry into the MSB is recovered from the MSB sum bit and its operands
      assign msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ part[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ovf <= 1'b0;
         end else if (advance && up_valid) begin
            ovf <= msb_cin ^ part[CHUNK];
         end
      end
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pipe_add.sv
// rtl/pipe_add.sv - pipelined WIDTH-bit add/subtract with valid/ready streaming
// PIPE_ADD_OVF_EN enables the registered signed-overflow flag on out_ovf.
module pipe_add
   import pipe_add_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   logic [STAGES:0][WIDTH-1:0] a_w;
   logic [STAGES:0][WIDTH-1:0] b_w;
   logic [STAGES:0][WIDTH-1:0] sum_w;
   logic [STAGES:0]            carry_w;
   logic [STAGES:0]            vin_w;
   logic [STAGES-1:0]          valid_q;
   logic [STAGES-1:0]          open_w;
   logic [STAGES-1:0]          adv_w;
   logic [STAGES-1:0]          ovf_w;

   assign a_w[0]     = in_a;
   assign b_w[0]     = (in_sub == OP_ADD) ? in_b : ~in_b;
   assign carry_w[0] = (in_sub == OP_SUB) ? 1'b1 : in_cin;
   assign sum_w[0]   = '0;
   assign vin_w      = {valid_q, in_valid};

   for (genvar k = 0; k < STAGES; k++) begin : g_rank
      // a rank may load when any rank below it is empty or the consumer takes the head
      if (k == STAGES - 1) begin : g_tail
         assign open_w[k] = out_ready;
      end else begin : g_body
         assign open_w[k] = out_ready || !(&valid_q[STAGES-1:k+1]);
      end

      pipe_add_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (vin_w[k]),
         .up_a     (a_w[k]),
         .up_b     (b_w[k]),
         .up_sum   (sum_w[k]),
         .up_carry (carry_w[k]),
         .dn_open  (open_w[k]),
         .advance  (adv_w[k]),
         .valid    (valid_q[k]),
         .a        (a_w[k+1]),
         .b        (b_w[k+1]),
         .sum      (sum_w[k+1]),
         .carry    (carry_w[k+1]),
         .ovf      (ovf_w[k])
      );
   end

   assign in_ready  = adv_w[0];
   assign out_valid = valid_q[STAGES-1];
   assign out_sum   = sum_w[STAGES];
   assign out_cout  = carry_w[STAGES];

`ifdef PIPE_ADD_OVF_EN
   assign out_ovf = ovf_w[STAGES-1];
`else
   assign out_ovf = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{a_w[STAGES], b_w[STAGES], adv_w, ovf_w};

endmodule

// File: tb/tb_pipe_add.sv
// tb/tb_pipe_add.sv - scoreboard bench for pipe_add: vector table, stall, reset, random streams
module tb_pipe_add;
   parameter int STAGES = 4;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   pipe_add #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   res_t q[$];
   res_t drv_exp;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   pop_cnt = 0;
   int   last_acc = 0;
   bit   stop_rand = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic ovf_gate(input logic o);
`ifdef PIPE_ADD_OVF_EN
      return o;
`else
      return o & 1'b0;
`endif
   endfunction

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      res_t        m;
      logic [32:0] r;
      if (sub) begin
         m.sum  = a - b;
         m.cout = (a >= b);
         m.ovf  = (a[31] != b[31]) && (m.sum[31] != a[31]);
      end else begin
         r      = {1'b0, a} + {1'b0, b} + {32'b0, cin};
         m.sum  = r[31:0];
         m.cout = r[32];
         m.ovf  = (a[31] == b[31]) && (m.sum[31] != a[31]);
      end
      m.ovf = ovf_gate(m.ovf);
      return m;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: transfers are judged at the negedge before the edge that completes them
   always @(negedge clk) begin : mon
      res_t f;
      if (rst_n) begin
         chk("in_ready", in_ready, out_ready || ((acc_cnt - pop_cnt) < STAGES));
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("out_valid_unexpected", out_valid, 1'b0);
            end else begin
               f = q[0];
               chk("out_sum", out_sum, f.sum);
               chk("out_cout", out_cout, f.cout);
               chk("out_ovf", out_ovf, f.ovf);
               if (out_ready) begin
                  void'(q.pop_front());
                  pop_cnt++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(drv_exp);
            acc_cnt++;
            last_acc = cyc;
         end
      end
   end

   // called at posedge+#1; returns at posedge+#1 right after the accepting edge
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input res_t e);
      bit ok;
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_sub = sub;
      drv_exp = e;
      in_valid = 1'b1;
      ok = 0;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      if (!ok) chk("accept_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub);
      send(a, b, cin, sub, model(a, b, cin, sub));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 4000 && q.size() != 0; n++) @(negedge clk);
      chk("drain_left", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      res_t e;
      int   first;
      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      in_sub = 1'b0;
      out_ready = 1'b1;
      drv_exp = '{32'h0, 1'b0, 1'b0};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum", out_sum, 32'h0);
      chk("rst_out_cout", out_cout, 1'b0);
      chk("rst_out_ovf", out_ovf, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // first vector alone measures latency from the acceptance cycle
      for (int i = 0; i < 10; i++) begin
         e.sum = vecs[i].sum;
         e.cout = vecs[i].cout;
         e.ovf = ovf_gate(vecs[i].ovf);
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
         if (i == 0) begin
            for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
            if (!out_valid) @(negedge clk);
            chk("latency", cyc - last_acc, STAGES);
            @(posedge clk);
            #1;
         end
      end
      drain();

      // six back-to-back beats with the consumer stalled mid-stream
      fork
         begin
            for (int i = 1; i <= 6; i++) send_m(i, 100 * i, 1'b0, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // reset with three beats in flight; none of them may reappear
      for (int i = 0; i < 3; i++) send_m(32'h0000_1000 + i, 32'h7, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_sum", out_sum, 32'h0);
      chk("midrst_out_cout", out_cout, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      q.delete();
      acc_cnt = 0;
      pop_cnt = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_m(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0);
      send_m(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1);
      drain();

      // throughput with the consumer always ready
      send_m($urandom, $urandom, 1'b0, 1'b0);
      first = last_acc;
      for (int i = 1; i < 50; i++) send_m($urandom, $urandom, 1'(i % 2), 1'(i % 3 == 0));
      chk("throughput", last_acc - first, 49);
      drain();

      // random stream against random back-pressure
      stop_rand = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++)
               send_m($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stop_rand = 1;
         end
         begin
            while (!stop_rand) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      repeat (3) @(negedge clk);
      chk("idle_out_valid", out_valid, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
